ysyx_24090003_mem_arbiter: RTL and testbench

Two-requester memory arbiter that lets the instruction fetch unit (IFU) and the load/store unit (LSU) share the core's single memory port. It sits between the fetch/load-store logic and the memory interface. It registers one winning request at a time and holds it on the memory bus until accepted. It then routes the registered response back to the requester that issued it, with exactly one transaction outstanding.

---
 rtl/ysyx_24090003_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ysyx_24090003_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090003_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24090003_mem_arbiter
//
// Shares the core's single memory port between the instruction fetch unit
// (IFU) and the load/store unit (LSU). One request is registered at a time,
// held on the memory bus until memory accepts it, and the response is routed
// back to the requester that issued it. Only one transaction is in flight.
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin on contention (last-grant register)
//              undefined -> fixed priority, LSU always wins contention
//
// Ports:
//   cpu_clk, cpu_rst          core clock / async active-high reset
//   ifu_req_valid/ready       IFU read request handshake, ifu_addr
//   ifu_resp_valid, ifu_rdata IFU response pulse and fetched word
//   lsu_req_valid/ready       LSU request handshake, lsu_addr/wen/wdata/wmask
//   lsu_resp_valid, lsu_rdata LSU response pulse and load data
//   mem_req_valid/ready       memory request handshake
//   mem_addr/wen/wdata/wmask  registered request fields driven to memory
//   mem_resp_valid, mem_rdata memory response
// ---------------------------------------------------------------------------
module ysyx_24090003_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_IFU,
    REQ_LSU,
    WAIT_IFU,
    WAIT_LSU
  } state_t;

  state_t state;
  state_t state_next;

  logic grant_lsu;
  logic ifu_accept;
  logic lsu_accept;

`ifdef ARB_RR_EN
  // 1 when the most recent accept went to the LSU; reset value means IFU,
  // so the first contention after reset is handed to the LSU.
  logic last_lsu;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      last_lsu <= 1'b0;
    end else if (ifu_accept || lsu_accept) begin
      last_lsu <= lsu_accept;
    end
  end
`endif

  // Winner selection. Only meaningful in IDLE; the ready outputs below
  // gate it with the state and the requester's own valid.
  always_comb begin
    grant_lsu = 1'b0;
    if (lsu_req_valid && !ifu_req_valid) begin
      grant_lsu = 1'b1;
    end else if (lsu_req_valid && ifu_req_valid) begin
`ifdef ARB_RR_EN
      grant_lsu = !last_lsu;
`else
      grant_lsu = 1'b1;
`endif
    end
  end

  assign ifu_req_ready = (state == IDLE) && ifu_req_valid && !grant_lsu;
  assign lsu_req_ready = (state == IDLE) && lsu_req_valid && grant_lsu;
  assign ifu_accept    = ifu_req_valid && ifu_req_ready;
  assign lsu_accept    = lsu_req_valid && lsu_req_ready;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Responses are only looked at in the WAIT states, so
  // a response arriving in IDLE or during the request handshake is dropped.
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_accept) begin
          state_next = REQ_LSU;
        end else if (ifu_accept) begin
          state_next = REQ_IFU;
        end
      end
      REQ_IFU: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_next = WAIT_IFU;
        end
      end
      REQ_LSU: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_next = WAIT_LSU;
        end
      end
      WAIT_IFU: begin
        if (mem_resp_valid) begin
          state_next = IDLE;
        end
      end
      WAIT_LSU: begin
        if (mem_resp_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request fields are captured on accept and held stable until the next
  // accept. A fetch always presents itself to memory as a plain read.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (lsu_accept) begin
      mem_addr  <= lsu_addr;
      mem_wen   <= lsu_wen;
      mem_wdata <= lsu_wdata;
      mem_wmask <= lsu_wmask;
    end else if (ifu_accept) begin
      mem_addr  <= ifu_addr;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end
  end

  // Response routing: one-cycle valid pulse to the owner, and the owner's
  // rdata register keeps its value until that owner's next response.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_rdata      <= '0;
    end else begin
      ifu_resp_valid <= (state == WAIT_IFU) && mem_resp_valid;
      lsu_resp_valid <= (state == WAIT_LSU) && mem_resp_valid;
      if ((state == WAIT_IFU) && mem_resp_valid) begin
        ifu_rdata <= mem_rdata;
      end
      if ((state == WAIT_LSU) && mem_resp_valid) begin
        lsu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24090003_mem_arbiter
//
// Directed bench for the IFU/LSU memory arbiter. The bench plays the memory
// side itself, pushes every expected response (owner + data) to a queue when
// it drives mem_resp_valid, and a monitor pops and compares each response
// pulse. Build with +define+ARB_RR_EN to exercise the round-robin variant.
// ---------------------------------------------------------------------------
module tb_ysyx_24090003_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                cpu_clk = 1'b0;
  logic                cpu_rst = 1'b1;
  logic                ifu_req_valid = 1'b0;
  logic                ifu_req_ready;
  logic [ADDR_W-1:0]   ifu_addr = '0;
  logic                ifu_resp_valid;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                lsu_req_valid = 1'b0;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr = '0;
  logic                lsu_wen = 1'b0;
  logic [DATA_W-1:0]   lsu_wdata = '0;
  logic [DATA_W/8-1:0] lsu_wmask = '0;
  logic                lsu_resp_valid;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                mem_req_valid;
  logic                mem_req_ready = 1'b0;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_resp_valid = 1'b0;
  logic [DATA_W-1:0]   mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  // Scoreboard entry: bit 32 = owner (1 = LSU), bits 31:0 = data.
  logic [32:0] exp_q[$];

  // Reference arbitration state: 1 when the last accept went to the LSU.
  logic model_last_lsu = 1'b0;

  // Sequence of owners granted during the contention run.
  logic grants[4];

  ysyx_24090003_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge cpu_clk) begin
    if (!cpu_rst && (ifu_resp_valid || lsu_resp_valid)) begin
      check_output("resp_one_hot", {63'd0, ifu_resp_valid && lsu_resp_valid}, 64'd0);
      if (exp_q.size() == 0) begin
        check_output("resp_unexpected", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check_output("resp_owner", {63'd0, lsu_resp_valid}, {63'd0, e[32]});
        check_output("resp_data", {32'd0, lsu_resp_valid ? lsu_rdata : ifu_rdata},
                     {32'd0, e[31:0]});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_mem_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    check_output({tag, "_resp_valids"}, {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    check_output({tag, "_rdatas"}, {ifu_rdata, lsu_rdata}, 64'd0);
    check_output({tag, "_mem_fields"}, {mem_addr, mem_wen, mem_wmask, 27'd0}, 64'd0);
    check_output({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
  endtask

  // One complete transaction. Must be entered at a negedge with the DUT in
  // IDLE; returns #1 after the negedge on which the response pulse is seen.
  task automatic apply_stimulus(input logic ifu_v, input logic lsu_v,
                                input logic hold_valid, input int stall,
                                input logic resp_at_hs, input int resp_gap,
                                input logic [31:0] rdata, output logic won_lsu);
    logic        w;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    ifu_req_valid = ifu_v;
    lsu_req_valid = lsu_v;
    #1;
    if (ifu_v && lsu_v) begin
`ifdef ARB_RR_EN
      w = !model_last_lsu;
`else
      w = 1'b1;
`endif
    end else begin
      w = lsu_v;
    end
    model_last_lsu = w;
    won_lsu = w;
    check_output("idle_ready", {62'd0, ifu_req_ready, lsu_req_ready}, {62'd0, !w, w});
    e_addr  = w ? lsu_addr : ifu_addr;
    e_wen   = w ? lsu_wen : 1'b0;
    e_wdata = w ? lsu_wdata : 32'd0;
    e_wmask = w ? lsu_wmask : 4'd0;

    @(negedge cpu_clk);
    if (!hold_valid) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
    end
    #1;
    for (int i = 0; i <= stall; i++) begin
      if (i != 0) begin
        @(negedge cpu_clk);
        #1;
      end
      check_output("req_valid", {63'd0, mem_req_valid}, 64'd1);
      check_output("req_ready_low", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      check_output("req_fields", {mem_addr, mem_wen, mem_wmask, 27'd0},
                   {e_addr, e_wen, e_wmask, 27'd0});
      check_output("req_wdata", {32'd0, mem_wdata}, {32'd0, e_wdata});
    end
    mem_req_ready  = 1'b1;
    mem_resp_valid = resp_at_hs;
    mem_rdata      = 32'hBAD0_0BAD;

    for (int i = 0; i <= resp_gap; i++) begin
      @(negedge cpu_clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      #1;
      check_output("wait_req_valid", {63'd0, mem_req_valid}, 64'd0);
      check_output("wait_ready_low", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      check_output("wait_no_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    exp_q.push_back({w, rdata});

    @(negedge cpu_clk);
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    #1;
    check_output("resp_pulse", {62'd0, ifu_resp_valid, lsu_resp_valid}, {62'd0, !w, w});
  endtask

  task automatic do_reset();
    ifu_req_valid  = 1'b0;
    lsu_req_valid  = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    cpu_rst        = 1'b1;
    model_last_lsu = 1'b0;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
  endtask

  initial begin
    logic won;

    // Reset state
    @(negedge cpu_clk);
    #1;
    check_reset_outputs("reset");
    check_output("reset_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    // Spurious response in IDLE is ignored
    @(negedge cpu_clk);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    @(negedge cpu_clk);
    mem_resp_valid = 1'b0;
    #1;
    check_output("idle_resp_ignored", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    check_output("idle_resp_rdata", {ifu_rdata, lsu_rdata}, 64'd0);

    // IFU fetch, memory ready at once, data one cycle after mem accept
    @(negedge cpu_clk);
    ifu_addr = 32'h8000_0000;
    apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0010_0093, won);
    @(negedge cpu_clk);
    #1;
    check_output("ifu_pulse_once", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    check_output("ifu_rdata_hold", {32'd0, ifu_rdata}, {32'd0, 32'h0010_0093});

    // LSU store with 4 stall cycles
    lsu_addr  = 32'h8000_0100;
    lsu_wen   = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 4'hF;
    apply_stimulus(1'b0, 1'b1, 1'b0, 4, 1'b0, 0, 32'hCAFE_0001, won);
    @(negedge cpu_clk);
    #1;
    check_output("lsu_pulse_once", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    check_output("ifu_rdata_kept", {32'd0, ifu_rdata}, {32'd0, 32'h0010_0093});

    // Response during the request handshake is dropped; later one counts
    lsu_addr  = 32'h8000_0204;
    lsu_wen   = 1'b0;
    lsu_wdata = 32'h0;
    lsu_wmask = 4'h0;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1, 1'b1, 2, 32'h5555_AAAA, won);

    // Contention from reset: both valid continuously for 4 transactions
    do_reset();
    @(negedge cpu_clk);
    ifu_addr  = 32'h8000_1000;
    lsu_addr  = 32'h8000_2000;
    lsu_wen   = 1'b1;
    lsu_wdata = 32'h0BAD_F00D;
    lsu_wmask = 4'h3;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b1, k % 2, 1'b0, k % 3, 32'hA000_0000 + k, won);
      grants[k] = won;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
`ifdef ARB_RR_EN
    check_output("rr_grants", {60'd0, grants[0], grants[1], grants[2], grants[3]},
                 {60'd0, 4'b1010});
`else
    check_output("fixed_grants", {60'd0, grants[0], grants[1], grants[2], grants[3]},
                 {60'd0, 4'b1111});
`endif

    // Reset while waiting on an LSU load, late response afterwards
    @(negedge cpu_clk);
    lsu_addr = 32'h8000_3000;
    lsu_wen  = 1'b0;
    lsu_req_valid = 1'b1;
    @(negedge cpu_clk);
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge cpu_clk);
    mem_req_ready = 1'b0;
    #2;
    cpu_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge cpu_clk);
    cpu_rst        = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h7777_7777;
    model_last_lsu = 1'b0;
    @(negedge cpu_clk);
    mem_resp_valid = 1'b0;
    #1;
    check_output("late_resp_ignored", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    check_output("late_resp_rdata", {32'd0, lsu_rdata}, 64'd0);
    @(negedge cpu_clk);
    ifu_addr = 32'h8000_0040;
    apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0000_0013, won);

    repeat (3) @(negedge cpu_clk);
    check_output("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung DUT handshake path.
  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

endmodule
